// File: rtl/des_pkg.sv
// des_pkg: shared DES constants and helpers.
//   - IP/FP/E/P/PC1/PC2 permutation tables (1-based, bit 1 = MSB; short
//     tables are zero-padded to 64 entries so one permute() serves all)
//   - the eight S-boxes, the key shift schedule and the core state enum
//   - permute, sbox_lookup, rotl28, rotr28
package des_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int IP_T [64] = '{
    58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
    62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
    57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
    61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};

  localparam int FP_T [64] = '{
    40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
    38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
    36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
    34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};

  localparam int E_T [64] = '{
    32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
    16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1,
    0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0};

  localparam int P_T [64] = '{
    16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
    2,8,24,14,32,27,3,9,    19,13,30,6,22,11,4,25,
    0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0};

  localparam int PC1_T [64] = '{
    57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
    19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
    14,6,61,53,45,37,29, 21,13,5,28,20,12,4,
    0,0,0,0,0,0,0,0};

  localparam int PC2_T [64] = '{
    14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
    41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32,
    0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0};

  localparam int SHIFTS [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  // Row-major: entry [row*16 + col].
  localparam int SBOX [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  // din is right-aligned in_w bits; result is right-aligned out_w bits.
  function automatic logic [63:0] permute(input logic [63:0] din, input int in_w,
                                          input int out_w, input int tbl [64]);
    logic [63:0] dout;
    dout = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < out_w) dout[6'(out_w - 1 - i)] = din[6'(in_w - tbl[i])];
    end
    return dout;
  endfunction

  // Outer bits select the row, inner four bits the column.
  function automatic logic [3:0] sbox_lookup(input logic [2:0] n, input logic [5:0] b);
    return 4'(SBOX[n][{b[5], b[0], b[4:1]}]);
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input int n);
    return (x << n) | (x >> (28 - n));
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input int n);
    return (x >> n) | (x << (28 - n));
  endfunction

endpackage

// File: rtl/des_round.sv
// des_round: one combinational DES Feistel round with on-the-fly subkey.
//   l_in/r_in   : 32-bit halves entering the round
//   c_in/d_in   : 28-bit key halves from the previous round
//   mode        : 0 = encrypt (rotate left), 1 = decrypt (rotate right)
//   round_idx   : round number 1..16
//   l_out/r_out : halves after the round
//   c_out/d_out : rotated key halves to feed the next round
module des_round
  import des_pkg::*;
(
  input  logic [31:0] l_in,
  input  logic [31:0] r_in,
  input  logic [27:0] c_in,
  input  logic [27:0] d_in,
  input  logic        mode,
  input  logic [4:0]  round_idx,
  output logic [31:0] l_out,
  output logic [31:0] r_out,
  output logic [27:0] c_out,
  output logic [27:0] d_out
);

  logic [3:0]  enc_sel;
  logic [3:0]  dec_sel;
  logic [47:0] x_bits;
  logic [31:0] s_out;

  always_comb begin
    // Indices wrap modulo 16 so out-of-range rounds (core idle) stay in-table.
    enc_sel = 4'(round_idx - 5'd1);
    dec_sel = 4'(5'd17 - round_idx);
    if (!mode) begin
      c_out = rotl28(c_in, SHIFTS[enc_sel]);
      d_out = rotl28(d_in, SHIFTS[enc_sel]);
    end else if (round_idx == 5'd1) begin
      // Decrypt starts from C16/D16, which equal C0/D0 after a full 28-bit turn.
      c_out = c_in;
      d_out = d_in;
    end else begin
      c_out = rotr28(c_in, SHIFTS[dec_sel]);
      d_out = rotr28(d_in, SHIFTS[dec_sel]);
    end

    x_bits = 48'(permute({32'd0, r_in}, 32, 48, E_T)) ^
             48'(permute({8'd0, c_out, d_out}, 56, 48, PC2_T));
    s_out = '0;
    for (int i = 0; i < 8; i++) begin
      s_out[28 - 4*i +: 4] = sbox_lookup(3'(i), x_bits[42 - 6*i +: 6]);
    end

    l_out = r_in;
    r_out = l_in ^ 32'(permute({32'd0, s_out}, 32, 32, P_T));
  end

endmodule

// File: rtl/des_iter_core.sv
// des_iter_core: iterative DES engine, UNROLL rounds per clock.
//   clk, reset (async, active low)
//   in_valid/in_ready  : input handshake; mode, key_in, data_in sampled on it
//   out_valid/out_ready: output handshake; data_out holds the result
//   busy               : high while rounds are being computed
module des_iter_core
  import des_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        mode,
  input  logic [63:0] key_in,
  input  logic [63:0] data_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] data_out,
  output logic        busy
);

  localparam int NCYC  = 16 / UNROLL;
  localparam int CNT_W = $clog2(16) + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(16);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8 || UNROLL == 16)) begin : g_bad_unroll
    $error("des_iter_core: UNROLL must be 1, 2, 4, 8 or 16 (NCYC=%0d)", NCYC);
  end

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [31:0]      l_reg, r_reg;
  logic [27:0]      c_reg, d_reg;
  logic             mode_reg;
  logic [63:0]      data_out_reg;

  logic [31:0]      l_chain [UNROLL+1];
  logic [31:0]      r_chain [UNROLL+1];
  logic [27:0]      c_chain [UNROLL+1];
  logic [27:0]      d_chain [UNROLL+1];

  logic [63:0]      ip_data;
  logic [55:0]      pc1_key;
  logic [63:0]      fp_out;
  logic [CNT_W:0]   cnt_sum;
  logic [CNT_W-1:0] cnt_next;
  logic             last_cycle;
  logic             accept;

  assign l_chain[0] = l_reg;
  assign r_chain[0] = r_reg;
  assign c_chain[0] = c_reg;
  assign d_chain[0] = d_reg;

  for (genvar gi = 0; gi < UNROLL; gi++) begin : g_round
    des_round u_round (
      .l_in      (l_chain[gi]),
      .r_in      (r_chain[gi]),
      .c_in      (c_chain[gi]),
      .d_in      (d_chain[gi]),
      .mode      (mode_reg),
      .round_idx (cnt_reg + CNT_W'(gi + 1)),
      .l_out     (l_chain[gi+1]),
      .r_out     (r_chain[gi+1]),
      .c_out     (c_chain[gi+1]),
      .d_out     (d_chain[gi+1])
    );
  end

  assign ip_data = permute(data_in, 64, 64, IP_T);
  assign pc1_key = 56'(permute(key_in, 64, 56, PC1_T));
  // Halves are swapped before the final permutation.
  assign fp_out  = permute({r_chain[UNROLL], l_chain[UNROLL]}, 64, 64, FP_T);

  // Counter saturates at 16 so it never wraps inside a block.
  assign cnt_sum    = {1'b0, cnt_reg} + (CNT_W+1)'(UNROLL);
  assign last_cycle = cnt_sum >= (CNT_W+1)'(16);
  assign cnt_next   = last_cycle ? CNT_FULL : cnt_sum[CNT_W-1:0];

  // DONE accepts a new block in the same clock as the result leaves.
  assign in_ready  = (state_reg == IDLE) || (state_reg == DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg == RUN);
  assign data_out  = data_out_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      l_reg        <= '0;
      r_reg        <= '0;
      c_reg        <= '0;
      d_reg        <= '0;
      mode_reg     <= 1'b0;
      data_out_reg <= '0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (accept) begin
            l_reg     <= ip_data[63:32];
            r_reg     <= ip_data[31:0];
            c_reg     <= pc1_key[55:28];
            d_reg     <= pc1_key[27:0];
            mode_reg  <= mode;
            cnt_reg   <= '0;
            state_reg <= RUN;
          end else if (state_reg == DONE && out_ready) begin
            state_reg <= IDLE;
          end
        end
        RUN: begin
          l_reg   <= l_chain[UNROLL];
          r_reg   <= r_chain[UNROLL];
          c_reg   <= c_chain[UNROLL];
          d_reg   <= d_chain[UNROLL];
          cnt_reg <= cnt_next;
          if (last_cycle) begin
            data_out_reg <= fp_out;
            state_reg    <= DONE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_des_iter_core.sv
// Bench for des_iter_core: five instances (UNROLL 1,2,4,8,16) share the
// input bus; only the selected one sees in_valid and is observed.
module tb_des_iter_core;

  localparam int NDUT = 5;
  localparam int UNR [NDUT] = '{1, 2, 4, 8, 16};

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        mode;
  logic        out_ready;
  logic [63:0] key_in;
  logic [63:0] data_in;

  logic        iv_a   [NDUT];
  logic        ir_a   [NDUT];
  logic        ov_a   [NDUT];
  logic        busy_a [NDUT];
  logic [63:0] dout_a [NDUT];

  int          sel = 0;
  logic        ir_s, ov_s, busy_s;
  logic [63:0] dout_s;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit ov_seen = 0;

  typedef struct {
    logic [63:0] key;
    logic [63:0] data;
    logic        mode;
    logic [63:0] exp;
  } vec_t;

  typedef struct {
    logic [63:0] exp;
    int          hs_cyc;
    int          lat;
  } sb_t;

  vec_t vecs [8];
  sb_t  sbq [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
    assign iv_a[gi] = in_valid && (sel == gi);
    des_iter_core #(.UNROLL(UNR[gi])) u_dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (iv_a[gi]),
      .in_ready  (ir_a[gi]),
      .mode      (mode),
      .key_in    (key_in),
      .data_in   (data_in),
      .out_valid (ov_a[gi]),
      .out_ready (out_ready),
      .data_out  (dout_a[gi]),
      .busy      (busy_a[gi])
    );
  end

  assign ir_s   = ir_a[sel];
  assign ov_s   = ov_a[sel];
  assign busy_s = busy_a[sel];
  assign dout_s = dout_a[sel];

  function automatic void chk64(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endfunction

  function automatic void chk_int(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endfunction

  // Output monitor: latency on first out_valid, data on output handshake.
  always @(negedge clk) begin
    if (reset) begin
      if (sbq.size() > 0) begin
        if (ov_s && !ov_seen) begin
          ov_seen = 1;
          chk_int("latency", cyc - sbq[0].hs_cyc, sbq[0].lat);
        end
        if (ov_s && out_ready) begin
          chk64("data_out", dout_s, sbq[0].exp);
          $display("txn unroll=%0d data_out=%h expected=%h", UNR[sel], dout_s, sbq[0].exp);
          void'(sbq.pop_front());
          ov_seen = 0;
        end
      end else if (ov_s && out_ready) begin
        chk_int("spurious_out_valid", 1, 0);
      end
    end
  end

  task automatic send(input logic [63:0] k, input logic [63:0] d,
                      input logic m, input logic [63:0] e);
    int n = 0;
    key_in   = k;
    data_in  = d;
    mode     = m;
    in_valid = 1'b1;
    @(negedge clk);
    while (!ir_s && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ir_s) begin
      chk_int("in_ready_timeout", 0, 1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      sbq.push_back(sb_t'{e, cyc, 16 / UNR[sel]});
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      chk_int("drain_timeout", sbq.size(), 0);
      sbq.delete();
      ov_seen = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    vecs[0] = '{64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0, 64'h85E813540F0AB405};
    vecs[1] = '{64'h133457799BBCDFF1, 64'h85E813540F0AB405, 1'b1, 64'h0123456789ABCDEF};
    vecs[2] = '{64'h0000000000000000, 64'h0000000000000000, 1'b0, 64'h8CA64DE9C1B123A7};
    vecs[3] = '{64'h0000000000000000, 64'h8CA64DE9C1B123A7, 1'b1, 64'h0000000000000000};
    vecs[4] = '{64'h0101010101010101, 64'h0000000000000000, 1'b0, 64'h8CA64DE9C1B123A7};
    vecs[5] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0, 64'h7359B2163E4EDC58};
    vecs[6] = '{64'h0E329232EA6D0D73, 64'h8787878787878787, 1'b0, 64'h0000000000000000};
    vecs[7] = '{64'h0E329232EA6D0D73, 64'h0000000000000000, 1'b1, 64'h8787878787878787};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    mode = 1'b0; key_in = '0; data_in = '0;
    #3 reset = 1'b0;
    #9;
    for (int s = 0; s < NDUT; s++) begin
      chk64("reset_in_ready", 64'(ir_a[s]), 64'd1);
      chk64("reset_out_valid", 64'(ov_a[s]), 64'd0);
      chk64("reset_busy", 64'(busy_a[s]), 64'd0);
      chk64("reset_data_out", dout_a[s], 64'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // Known answers on every UNROLL, issued back to back.
    for (int s = 0; s < NDUT; s++) begin
      sel = s;
      for (int v = 0; v < 8; v++) send(vecs[v].key, vecs[v].data, vecs[v].mode, vecs[v].exp);
      drain();
    end

    // Backpressure, then simultaneous output and input handshakes.
    sel = 0;
    out_ready = 1'b0;
    send(vecs[0].key, vecs[0].data, 1'b0, vecs[0].exp);
    n = 0;
    while (!ov_s && n < 100) begin @(negedge clk); n++; end
    chk64("bp_out_valid", 64'(ov_s), 64'd1);
    repeat (10) begin
      @(negedge clk);
      chk64("bp_hold_data", dout_s, vecs[0].exp);
      chk64("bp_in_ready", 64'(ir_s), 64'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(vecs[2].key, vecs[2].data, 1'b0, vecs[2].exp);
    chk64("b2b_busy", 64'(busy_s), 64'd1);
    chk64("b2b_out_valid", 64'(ov_s), 64'd0);
    drain();

    // Reset five clocks into RUN discards the block asynchronously.
    send(vecs[5].key, vecs[5].data, 1'b0, vecs[5].exp);
    repeat (5) @(posedge clk);
    #1;
    chk64("pre_reset_busy", 64'(busy_s), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk64("mid_reset_out_valid", 64'(ov_s), 64'd0);
    chk64("mid_reset_in_ready", 64'(ir_s), 64'd1);
    chk64("mid_reset_busy", 64'(busy_s), 64'd0);
    chk64("mid_reset_data_out", dout_s, 64'd0);
    sbq.delete();
    ov_seen = 0;
    @(posedge clk); #1;
    reset = 1'b1;
    send(vecs[0].key, vecs[0].data, 1'b0, vecs[0].exp);
    drain();

    // Inputs toggled during RUN must not affect the result.
    for (int t = 0; t < 2; t++) begin
      if (t == 0) send(vecs[6].key, vecs[6].data, 1'b0, vecs[6].exp);
      else        send(vecs[1].key, vecs[1].data, 1'b1, vecs[1].exp);
      repeat (20) begin
        @(posedge clk); #1;
        key_in  = {$urandom, $urandom};
        data_in = {$urandom, $urandom};
        mode    = 1'($urandom_range(0, 1));
      end
      drain();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
